// File: rtl/tpu_package.sv
// Shared widths, FSM state type and write-slot payload for the weight loader.
package tpu_package;

  localparam int unsigned MUL_SIZE  = 32;  // rows per tile and tile edge length
  localparam int unsigned ROW_W     = 5;   // tile row index width
  localparam int unsigned ADDR_W    = 16;  // DRAM row address width
  localparam int unsigned DIM_W     = 9;   // matrix dimension input width
  localparam int unsigned TILE_W    = 4;   // tile coordinate width (0..15)
  localparam int unsigned TCNT_W    = 5;   // tiles-per-axis count width (1..16)
  localparam int unsigned REQ_CNT_W = 6;   // request counter, reaches MUL_SIZE
  localparam int unsigned IDX_W     = 9;   // linear tile index width

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQUEST   = 2'd1,
    ST_WAIT_SLOT = 2'd2
  } wl_state_e;

  // One weight-buffer write, staged one cycle behind the returned row.
  typedef struct packed {
    logic             en;
    logic             last;
    logic             bank;
    logic [ROW_W-1:0] row;
  } wr_slot_t;

endpackage

// File: rtl/weight_tile_addr_gen.sv
// Tile walker: y inner, x outer; registered DRAM base row of the current tile.
module weight_tile_addr_gen
  import tpu_package::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              advance_i,
  input  logic [DIM_W-1:0]  h_dim_i,
  input  logic [DIM_W-1:0]  w_dim_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  output logic [ADDR_W-1:0] base_addr_o,
  output logic              last_tile_o
);

  logic [TCNT_W-1:0] tiles_y_q, tiles_y_d;
  logic [TCNT_W-1:0] tiles_x_q, tiles_x_d;
  logic [TILE_W-1:0] x_q, x_d;
  logic [TILE_W-1:0] y_q, y_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  tile_idx_c;
  logic              unused_dims_c;

  // Only the tile-granular part of the dimensions matters here.
  assign unused_dims_c = ^{h_dim_i[ROW_W-1:0], w_dim_i[ROW_W-1:0]};

  // Next tile coordinates and the base address they map to.
  always_comb begin
    tiles_y_d = tiles_y_q;
    tiles_x_d = tiles_x_q;
    x_d       = x_q;
    y_d       = y_q;
    start_d   = start_q;
    if (start_i) begin
      tiles_y_d = TCNT_W'(h_dim_i[DIM_W-1:ROW_W]) + TCNT_W'(1);
      tiles_x_d = TCNT_W'(w_dim_i[DIM_W-1:ROW_W]) + TCNT_W'(1);
      start_d   = start_addr_i;
      x_d       = '0;
      y_d       = '0;
    end else if (advance_i) begin
      if (y_q == TILE_W'(tiles_y_q - TCNT_W'(1))) begin
        y_d = '0;
        x_d = x_q + TILE_W'(1);
      end else begin
        y_d = y_q + TILE_W'(1);
      end
    end
    tile_idx_c = IDX_W'(x_d) * IDX_W'(tiles_y_d) + IDX_W'(y_d);
    base_d     = start_d + ADDR_W'({tile_idx_c, {ROW_W{1'b0}}});
    last_d     = (x_d == TILE_W'(tiles_x_d - TCNT_W'(1))) &&
                 (y_d == TILE_W'(tiles_y_d - TCNT_W'(1)));
  end

  // Walker state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tiles_y_q <= '0;
      tiles_x_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      start_q   <= '0;
      base_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      tiles_y_q <= tiles_y_d;
      tiles_x_q <= tiles_x_d;
      x_q       <= x_d;
      y_q       <= y_d;
      start_q   <= start_d;
      base_q    <= base_d;
      last_q    <= last_d;
    end
  end

  assign base_addr_o = base_q;
  assign last_tile_o = last_q;

endmodule

// File: rtl/weight_load_control_unit.sv
// Streams weight tiles from DRAM into a double-buffered weight store and
// hands full banks to the compute side.
module weight_load_control_unit
  import tpu_package::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instruction_i,
  input  logic [DIM_W-1:0]  H_DIM_i,
  input  logic [DIM_W-1:0]  W_DIM_i,
  input  logic [ADDR_W-1:0] weight_start_addr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_req_ready_i,
  input  logic              mem_rdata_valid_i,
  output logic              weight_wr_en_o,
  output logic              weight_wr_bank_o,
  output logic [ROW_W-1:0]  weight_wr_row_o,
  input  logic              next_weight_tile_i,
  output logic              compute_weights_rdy_o,
  output logic              compute_weights_buffered_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  wl_state_e            state_q, state_d;
  logic                 req_q, req_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [REQ_CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [ROW_W-1:0]     ret_cnt_q, ret_cnt_d;
  logic [REQ_CNT_W-1:0] outst_q, outst_d;
  logic                 fill_bank_q, fill_bank_d;
  logic                 read_bank_q, read_bank_d;
  logic [1:0]           full_q, full_d;
  logic                 all_filled_q, all_filled_d;
  wr_slot_t             wr_q, wr_d;
  logic                 rdy_q, rdy_d;
  logic                 buf_q, buf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic                 accept_c;
  logic                 rvalid_ok_c;
  logic                 tile_done_c;
  logic                 gen_start_c;
  logic                 gen_advance_c;
  logic [ADDR_W-1:0]    gen_base;
  logic                 gen_last;

  assign accept_c    = req_q & mem_req_ready_i;
  assign rvalid_ok_c = mem_rdata_valid_i && (outst_q != '0);
  assign tile_done_c = wr_q.en && wr_q.last;

  weight_tile_addr_gen u_addr_gen (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (gen_start_c),
    .advance_i    (gen_advance_c),
    .h_dim_i      (H_DIM_i),
    .w_dim_i      (W_DIM_i),
    .start_addr_i (weight_start_addr_i),
    .base_addr_o  (gen_base),
    .last_tile_o  (gen_last)
  );

  // Next-state, bank bookkeeping, request and write-stage logic.
  always_comb begin
    state_d       = state_q;
    req_cnt_d     = req_cnt_q + REQ_CNT_W'(accept_c);
    ret_cnt_d     = ret_cnt_q;
    outst_d       = outst_q + REQ_CNT_W'(accept_c) - REQ_CNT_W'(rvalid_ok_c);
    fill_bank_d   = fill_bank_q;
    read_bank_d   = read_bank_q;
    full_d        = full_q;
    all_filled_d  = all_filled_q;
    wr_d          = '0;
    done_d        = 1'b0;
    error_d       = error_q;
    addr_d        = addr_q;
    req_d         = 1'b0;
    gen_start_c   = 1'b0;
    gen_advance_c = 1'b0;

    // Returned rows become writes; strays only count as errors during a job,
    // so rows still in flight from an aborted job die quietly in IDLE.
    if (mem_rdata_valid_i) begin
      if (outst_q != '0) begin
        wr_d.en   = 1'b1;
        wr_d.last = (ret_cnt_q == ROW_W'(MUL_SIZE - 1));
        wr_d.bank = fill_bank_q;
        wr_d.row  = ret_cnt_q;
        ret_cnt_d = ret_cnt_q + ROW_W'(1);
      end else if (busy_q) begin
        error_d = 1'b1;
      end
    end

    // Tile completion fills one bank while the compute side may free the other.
    if (tile_done_c) begin
      full_d[fill_bank_q] = 1'b1;
      fill_bank_d         = ~fill_bank_q;
    end
    if (next_weight_tile_i) begin
      if (full_q[read_bank_q]) begin
        full_d[read_bank_q] = 1'b0;
        read_bank_d         = ~read_bank_q;
      end else begin
        error_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (instruction_i) begin
          state_d      = ST_REQUEST;
          gen_start_c  = 1'b1;
          req_cnt_d    = '0;
          ret_cnt_d    = '0;
          fill_bank_d  = 1'b0;
          read_bank_d  = 1'b0;
          full_d       = 2'b00;
          all_filled_d = 1'b0;
        end
      end
      ST_REQUEST: begin
        if (tile_done_c) begin
          req_cnt_d = '0;
          if (gen_last) begin
            all_filled_d = 1'b1;
            state_d      = ST_WAIT_SLOT;
          end else begin
            gen_advance_c = 1'b1;
            state_d       = full_d[fill_bank_d] ? ST_WAIT_SLOT : ST_REQUEST;
          end
        end
      end
      ST_WAIT_SLOT: begin
        if (all_filled_q) begin
          if (full_d == 2'b00) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (!full_d[fill_bank_q]) begin
          state_d = ST_REQUEST;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A request stays up with a stable address until the tile's rows are all accepted.
    if ((state_q == ST_REQUEST) && !tile_done_c &&
        (req_cnt_d < REQ_CNT_W'(MUL_SIZE))) begin
      req_d  = 1'b1;
      addr_d = gen_base + ADDR_W'(req_cnt_d[ROW_W-1:0]);
    end

    busy_d = (state_d != ST_IDLE);
    rdy_d  = full_d[read_bank_d];
    buf_d  = full_d[~read_bank_d];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      req_cnt_q    <= '0;
      ret_cnt_q    <= '0;
      outst_q      <= '0;
      fill_bank_q  <= 1'b0;
      read_bank_q  <= 1'b0;
      full_q       <= 2'b00;
      all_filled_q <= 1'b0;
      wr_q         <= '0;
      rdy_q        <= 1'b0;
      buf_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      req_cnt_q    <= req_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      outst_q      <= outst_d;
      fill_bank_q  <= fill_bank_d;
      read_bank_q  <= read_bank_d;
      full_q       <= full_d;
      all_filled_q <= all_filled_d;
      wr_q         <= wr_d;
      rdy_q        <= rdy_d;
      buf_q        <= buf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign mem_req_o                  = req_q;
  assign mem_addr_o                 = addr_q;
  assign weight_wr_en_o             = wr_q.en;
  assign weight_wr_bank_o           = wr_q.bank;
  assign weight_wr_row_o            = wr_q.row;
  assign compute_weights_rdy_o      = rdy_q;
  assign compute_weights_buffered_o = buf_q;
  assign busy_o                     = busy_q;
  assign done_o                     = done_q;
  assign error_o                    = error_q;

endmodule

// File: tb/tb_weight_load_control_unit.sv
// Directed bench with a DRAM responder and address/write scoreboards.
module tb_weight_load_control_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instruction_i;
  logic [8:0]  H_DIM_i;
  logic [8:0]  W_DIM_i;
  logic [15:0] weight_start_addr_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_req_ready_i;
  logic        mem_rdata_valid_i;
  logic        weight_wr_en_o;
  logic        weight_wr_bank_o;
  logic [4:0]  weight_wr_row_o;
  logic        next_weight_tile_i;
  logic        compute_weights_rdy_o;
  logic        compute_weights_buffered_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int tests    = 0;
  int fails    = 0;
  int wr_count = 0;
  int acc_cnt  = 0;

  logic [15:0] exp_addr_q[$];
  logic [5:0]  exp_wr_q[$];
  bit          rand_ready  = 1'b0;
  bit          extra_valid = 1'b0;
  bit   [1:0]  ret_pipe    = 2'b00;

  always #5 clk_i = ~clk_i;

  weight_load_control_unit dut (
    .clk_i                      (clk_i),
    .rst_i                      (rst_i),
    .instruction_i              (instruction_i),
    .H_DIM_i                    (H_DIM_i),
    .W_DIM_i                    (W_DIM_i),
    .weight_start_addr_i        (weight_start_addr_i),
    .mem_req_o                  (mem_req_o),
    .mem_addr_o                 (mem_addr_o),
    .mem_req_ready_i            (mem_req_ready_i),
    .mem_rdata_valid_i          (mem_rdata_valid_i),
    .weight_wr_en_o             (weight_wr_en_o),
    .weight_wr_bank_o           (weight_wr_bank_o),
    .weight_wr_row_o            (weight_wr_row_o),
    .next_weight_tile_i         (next_weight_tile_i),
    .compute_weights_rdy_o      (compute_weights_rdy_o),
    .compute_weights_buffered_o (compute_weights_buffered_o),
    .busy_o                     (busy_o),
    .done_o                     (done_o),
    .error_o                    (error_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // DRAM model: ready (optionally random), each accepted row returns 2 cycles later.
  initial begin : responder
    bit accept;
    mem_req_ready_i   = 1'b0;
    mem_rdata_valid_i = 1'b0;
    forever begin
      @(negedge clk_i);
      mem_req_ready_i   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_rdata_valid_i = ret_pipe[1] | extra_valid;
      accept            = (mem_req_o === 1'b1) && mem_req_ready_i;
      ret_pipe          = {ret_pipe[0], accept};
      if (accept) begin
        acc_cnt++;
        chk("mem_addr", 32'(mem_addr_o),
            (exp_addr_q.size() > 0) ? 32'(exp_addr_q.pop_front()) : 32'hFFFF_FFFF);
      end
      if (weight_wr_en_o === 1'b1) begin
        wr_count++;
        chk("wr_bank_row", 32'({weight_wr_bank_o, weight_wr_row_o}),
            (exp_wr_q.size() > 0) ? 32'(exp_wr_q.pop_front()) : 32'hFFFF_FFFF);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic start_job(input logic [8:0] h, input logic [8:0] w, input logic [15:0] a);
    int ty, tx, t;
    ty = int'(h >> 5) + 1;
    tx = int'(w >> 5) + 1;
    t  = 0;
    for (int x = 0; x < tx; x++) begin
      for (int y = 0; y < ty; y++) begin
        for (int r = 0; r < 32; r++) begin
          exp_addr_q.push_back(16'(int'(a) + (x * ty + y) * 32 + r));
          exp_wr_q.push_back({1'(t % 2), 5'(r)});
        end
        t++;
      end
    end
    H_DIM_i             = h;
    W_DIM_i             = w;
    weight_start_addr_i = a;
    instruction_i       = 1'b1;
    tick(1);
    instruction_i       = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n = 0;
    while ((exp_addr_q.size() + exp_wr_q.size() > 0) && n < bound) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(exp_addr_q.size() + exp_wr_q.size()), 32'd0);
  endtask

  task automatic wait_rdy(input string tag, input int bound);
    int n = 0;
    while (compute_weights_rdy_o !== 1'b1 && n < bound) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(compute_weights_rdy_o), 32'd1);
  endtask

  task automatic release_tile();
    next_weight_tile_i = 1'b1;
    tick(1);
    next_weight_tile_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
    chk({tag, "_wr_en"}, 32'(weight_wr_en_o), 32'd0);
    chk({tag, "_rdy"}, 32'(compute_weights_rdy_o), 32'd0);
    chk({tag, "_buffered"}, 32'(compute_weights_buffered_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_error"}, 32'(error_o), 32'd0);
  endtask

  // Single-tile job that is released once and must complete.
  task automatic run_single(input logic [15:0] a, input string tag);
    int wr0 = wr_count;
    start_job(9'd31, 9'd31, a);
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    weight_start_addr_i = 16'h7777;
    H_DIM_i             = 9'h1FF;
    instruction_i       = 1'b1;
    tick(1);
    instruction_i       = 1'b0;
    wait_drain({tag, "_drain"}, 400);
    wait_rdy({tag, "_rdy"}, 20);
    chk({tag, "_buffered"}, 32'(compute_weights_buffered_o), 32'd0);
    chk({tag, "_req_idle"}, 32'(mem_req_o), 32'd0);
    chk({tag, "_writes"}, 32'(wr_count - wr0), 32'd32);
    release_tile();
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_busy_clr"}, 32'(busy_o), 32'd0);
    chk({tag, "_rdy_clr"}, 32'(compute_weights_rdy_o), 32'd0);
    tick(1);
    chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int wr0, acc0, n;
    rst_i               = 1'b1;
    instruction_i       = 1'b0;
    H_DIM_i             = '0;
    W_DIM_i             = '0;
    weight_start_addr_i = '0;
    next_weight_tile_i  = 1'b0;
    tick(3);
    rst_i = 1'b0;
    tick(1);
    chk_all_zero("reset");

    // One tile at 0x0100, late instruction ignored, one release completes.
    run_single(16'h0100, "single");

    // Two tiles along y, no release: both banks full, no further requests.
    start_job(9'd63, 9'd31, 16'h0000);
    wait_drain("two_drain", 600);
    wait_rdy("two_rdy", 20);
    tick(3);
    chk("two_buffered", 32'(compute_weights_buffered_o), 32'd1);
    chk("two_req_idle", 32'(mem_req_o), 32'd0);
    chk("two_busy", 32'(busy_o), 32'd1);
    release_tile();
    chk("two_rdy_bank1", 32'(compute_weights_rdy_o), 32'd1);
    chk("two_buffered_clr", 32'(compute_weights_buffered_o), 32'd0);
    chk("two_no_done", 32'(done_o), 32'd0);
    release_tile();
    chk("two_done", 32'(done_o), 32'd1);

    // Four tiles with random ready stalls and delayed releases.
    rand_ready = 1'b1;
    wr0 = wr_count;
    start_job(9'd63, 9'd63, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      wait_rdy($sformatf("four_rdy%0d", k), 1500);
      tick($urandom_range(0, 20));
      release_tile();
    end
    chk("four_done", 32'(done_o), 32'd1);
    chk("four_writes", 32'(wr_count - wr0), 32'd128);
    chk("four_queues", 32'(exp_addr_q.size() + exp_wr_q.size()), 32'd0);
    rand_ready = 1'b0;
    tick(2);

    // Release on an empty bank: sticky error, banks untouched.
    release_tile();
    chk("empty_rel_error", 32'(error_o), 32'd1);
    chk("empty_rel_rdy", 32'(compute_weights_rdy_o), 32'd0);
    chk("empty_rel_buf", 32'(compute_weights_buffered_o), 32'd0);
    tick(5);
    chk("empty_rel_sticky", 32'(error_o), 32'd1);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    chk("empty_rel_rst", 32'(error_o), 32'd0);

    // Abort around request 10 of tile 0; late returns must be ignored.
    acc0 = acc_cnt;
    start_job(9'd31, 9'd31, 16'h0100);
    n = 0;
    while ((acc_cnt - acc0) < 10 && n < 200) begin
      tick(1);
      n++;
    end
    chk("abort_reached", 32'((acc_cnt - acc0) >= 10), 32'd1);
    rst_i = 1'b1;
    tick(1);
    exp_addr_q.delete();
    exp_wr_q.delete();
    chk_all_zero("abort");
    rst_i = 1'b0;
    tick(6);
    chk("abort_late_error", 32'(error_o), 32'd0);
    chk("abort_late_busy", 32'(busy_o), 32'd0);
    run_single(16'h0100, "restart");

    // Address wrap at 0xFFFF plus a stray return before any request.
    wr0 = wr_count;
    start_job(9'd31, 9'd31, 16'hFFF0);
    extra_valid = 1'b1;
    tick(1);
    extra_valid = 1'b0;
    tick(1);
    chk("stray_error", 32'(error_o), 32'd1);
    wait_drain("wrap_drain", 400);
    wait_rdy("wrap_rdy", 20);
    chk("wrap_writes", 32'(wr_count - wr0), 32'd32);
    release_tile();
    chk("wrap_done", 32'(done_o), 32'd1);
    chk("wrap_error_sticky", 32'(error_o), 32'd1);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weight_load_control_unit.md
WEIGHT_LOAD_CONTROL_UNIT -- requirements
Module: weight_load_control_unit

Interface
REQ-001 SHALL provide clk_i, input, 1: single clock, all state on rising edge.
REQ-002 SHALL provide rst_i, input, 1: reset, synchronous, active-high.
REQ-003 SHALL provide instruction_i, input, 1: start pulse, sampled only in IDLE.
REQ-004 SHALL provide H_DIM_i and W_DIM_i, input, 9 each: matrix dims; tiles_y=(H_DIM_i>>5)+1, tiles_x=(W_DIM_i>>5)+1.
REQ-005 SHALL provide weight_start_addr_i, input, 16: DRAM row address of tile (0,0), latched at start.
REQ-006 SHALL provide mem_req_o, output, 1, and mem_addr_o, output, 16: row read request/address, held until accepted.
REQ-007 SHALL provide mem_req_ready_i, input, 1: request accepted when mem_req_o & mem_req_ready_i.
REQ-008 SHALL provide mem_rdata_valid_i, input, 1: one returned row per pulse, in request order.
REQ-009 SHALL provide weight_wr_en_o (1), weight_wr_bank_o (1), weight_wr_row_o (5), all outputs: weight-buffer write strobe, bank, row.
REQ-010 SHALL provide next_weight_tile_i, input, 1: compute side releases the current bank.
REQ-011 SHALL provide compute_weights_rdy_o and compute_weights_buffered_o, outputs, 1 each: current bank full; other bank full.
REQ-012 SHALL provide busy_o, done_o, error_o, outputs, 1 each: job active; one-cycle completion pulse; sticky protocol error.

Function
REQ-013 States SHALL be IDLE, REQUEST, WAIT_SLOT.
REQ-014 IDLE->REQUEST on instruction_i; latch dims/address, clear tile counters, set busy_o, fill bank=0, read bank=0.
REQ-015 Tile order SHALL be y inner, x outer; tile (x,y) base = start + (x*tiles_y + y)*32, 16-bit wrap-around.
REQ-016 REQUEST: mem_addr_o = base + req_cntr; req_cntr (6-bit) increments per accepted request; after 32 accepted, stop requesting.
REQ-017 Each mem_rdata_valid_i SHALL produce weight_wr_en_o one cycle later, with row = ret_cntr (5-bit) and bank = fill bank; ret_cntr increments.
REQ-018 32nd returned row SHALL set full[fill bank] one cycle after its write strobe, toggle fill bank, advance tile counters.
REQ-019 After last tile's requests, go to IDLE-pending-drain (stay REQUEST with mem_req_o=0) until returns complete; then wait for all banks consumed.
REQ-020 New tile requests SHALL start only when full[fill bank]=0; otherwise state WAIT_SLOT, mem_req_o=0.
REQ-021 compute_weights_rdy_o = full[read bank]; compute_weights_buffered_o = full[~read bank]; both registered.
REQ-022 next_weight_tile_i with full[read bank]=1 SHALL clear it and toggle read bank; with full[read bank]=0 SHALL be ignored and set error_o.
REQ-023 Same-cycle tile completion and release on different banks SHALL both take effect; WAIT_SLOT->REQUEST the next cycle.
REQ-024 done_o SHALL pulse one cycle when last tile released; state->IDLE, busy_o=0.
REQ-025 instruction_i while busy_o SHALL be ignored.
REQ-026 mem_rdata_valid_i outside an outstanding request SHALL set error_o and produce no write.

Reset
REQ-027 rst_i SHALL force IDLE, all counters/banks 0, full=00; outputs mem_req_o, weight_wr_en_o, rdy, buffered, busy_o, done_o, error_o = 0; addresses 0.
REQ-028 rst_i mid-job SHALL abort immediately; returns after reset are ignored, no error.

Structure
REQ-029 MUL_SIZE (32), tile row width and state enum SHALL live in tpu_package.
REQ-030 A sub-module weight_tile_addr_gen (tile counters + base address) is natural; otherwise single module.

Verification
REQ-031 H=W=31, start=0x0100, ready=1, valid 2 cycles after accept -> 32 reads 0x0100..0x011F, rdy=1, one release -> done_o pulse.
REQ-032 H=63, W=31, no releases -> tiles 0x0000, 0x0020 fill banks 0,1; buffered=1; WAIT_SLOT, mem_req_o=0; release -> rdy stays 1 (bank 1), buffered=0.
REQ-033 H=W=63, random ready stalls -> tile bases 0,32,64,96 in order; exactly 128 writes; done after 4 releases.
REQ-034 release on empty bank -> error_o=1, stays 1 until rst_i; bank state unchanged.
REQ-035 Reset at request 10 of tile 0 -> all outputs 0 next cycle; late valids ignored; new start behaves as REQ-031.
REQ-036 start=0xFFF0 -> mem_addr_o wraps 0xFFFF->0x0000 at row 16.
